// File: rtl/ttt_referee.sv
// Tic-tac-toe referee: takes agent/opponent moves over valid/ready, keeps the
// 18-bit board and reports win/lose/draw/continue after each applied move.
module ttt_referee (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_game,
  input  logic        first_player,
  input  logic        move_valid,
  input  logic        move_player,
  input  logic [3:0]  move_cell,
  output logic        move_ready,
  output logic        move_accept,
  output logic        move_reject,
  output logic [17:0] board,
  output logic        turn,
  output logic [3:0]  move_count,
  output logic [1:0]  game_state,
  output logic        state_valid
);

  typedef enum logic [1:0] {PLAY, EVAL, DONE} state_t;

  state_t      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic        turn_q, turn_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  gs_q, gs_d;
  logic        accept_q, accept_d;
  logic        reject_q, reject_d;
  logic        sv_q, sv_d;

  logic [1:0]  cell_val;
  logic        legal;
  logic [8:0]  agent_cells;
  logic [8:0]  opp_cells;

  function automatic logic line_win(input logic [8:0] c);
    return (c[0] & c[1] & c[2]) | (c[3] & c[4] & c[5]) | (c[6] & c[7] & c[8]) |
           (c[0] & c[3] & c[6]) | (c[1] & c[4] & c[7]) | (c[2] & c[5] & c[8]) |
           (c[0] & c[4] & c[8]) | (c[2] & c[4] & c[6]);
  endfunction

  // Out-of-range cells leave cell_val nonzero so they read as occupied.
  always_comb begin
    cell_val = 2'b11;
    for (int i = 0; i < 9; i++) begin
      if (move_cell == i[3:0]) cell_val = board_q[2*i +: 2];
      agent_cells[i] = (board_q[2*i +: 2] == 2'b01);
      opp_cells[i]   = (board_q[2*i +: 2] == 2'b10);
    end
    legal = (cell_val == 2'b00) && (move_player == turn_q);
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    turn_d   = turn_q;
    count_d  = count_q;
    gs_d     = gs_q;
    accept_d = 1'b0;
    reject_d = 1'b0;
    sv_d     = 1'b0;
    if (new_game) begin
      state_d = PLAY;
      board_d = '0;
      turn_d  = first_player;
      count_d = '0;
      gs_d    = 2'b00;
    end else begin
      case (state_q)
        PLAY: begin
          if (move_valid) begin
            if (legal) begin
              for (int i = 0; i < 9; i++) begin
                if (move_cell == i[3:0]) board_d[2*i +: 2] = move_player ? 2'b10 : 2'b01;
              end
              count_d  = (count_q == 4'd9) ? count_q : count_q + 4'd1;
              turn_d   = ~turn_q;
              accept_d = 1'b1;
              state_d  = EVAL;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        EVAL: begin
          sv_d = 1'b1;
          if (line_win(agent_cells)) begin
            gs_d    = 2'b10;
            state_d = DONE;
          end else if (line_win(opp_cells)) begin
            gs_d    = 2'b11;
            state_d = DONE;
          end else if (count_q == 4'd9) begin
            gs_d    = 2'b01;
            state_d = DONE;
          end else begin
            gs_d    = 2'b00;
            state_d = PLAY;
          end
        end
        DONE: begin
          if (move_valid) reject_d = 1'b1;
        end
        default: state_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PLAY;
      board_q  <= '0;
      turn_q   <= 1'b0;
      count_q  <= '0;
      gs_q     <= 2'b00;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      sv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      turn_q   <= turn_d;
      count_q  <= count_d;
      gs_q     <= gs_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      sv_q     <= sv_d;
    end
  end

  assign move_ready  = (state_q != EVAL);
  assign move_accept = accept_q;
  assign move_reject = reject_q;
  assign board       = board_q;
  assign turn        = turn_q;
  assign move_count  = count_q;
  assign game_state  = gs_q;
  assign state_valid = sv_q;

endmodule
